// File: rtl/inst_loader_if.sv
// Host/SRAM-side bundle for the microcode instruction loader.
// The loader sits on the slave modport; the host/bench drives the master modport.
interface inst_loader_if;
  logic         LOAD_START;
  logic [13:0]  LOAD_LEN;
  logic         HOST_VALID;
  logic [31:0]  HOST_DATA;
  logic         HOST_READY;
  logic [13:0]  WADDRI;
  logic         WCEBI;
  logic [127:0] DI;
  logic         PURGE;
  logic         LOAD_BUSY;
  logic         LOAD_DONE;
  logic [31:0]  CHECKSUM;

  modport master (
    output LOAD_START, LOAD_LEN, HOST_VALID, HOST_DATA,
    input  HOST_READY, WADDRI, WCEBI, DI, PURGE, LOAD_BUSY, LOAD_DONE, CHECKSUM
  );

  modport slave (
    input  LOAD_START, LOAD_LEN, HOST_VALID, HOST_DATA,
    output HOST_READY, WADDRI, WCEBI, DI, PURGE, LOAD_BUSY, LOAD_DONE, CHECKSUM
  );
endinterface

// File: rtl/inst_loader.sv
// Collects 32-bit host beats into 128-bit lines and writes them to instruction SRAM.
// Optional running XOR checksum of accepted beats: define INST_LOADER_CHECKSUM_EN.
module inst_loader (
  input  logic CLK,
  input  logic RSTL,
  inst_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t       state;
  logic [13:0]  len_q;
  logic [13:0]  line_cnt;
  logic [1:0]   beat_cnt;
  logic [95:0]  line_buf;
  logic         ready_q;
  logic         wceb_q;
  logic [13:0]  waddr_q;
  logic [127:0] di_q;
  logic         busy_q;
  logic         done_q;

  logic start_ok;
  logic beat_ok;

  assign start_ok = (state == IDLE) && bus.LOAD_START;
  assign beat_ok  = (state == COLLECT) && ready_q && bus.HOST_VALID;

  // NOTE: every register below updates with <= so all of them see pre-edge
  // values of one another; a blocking = here would create order-dependent races.
  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      state    <= IDLE;
      len_q    <= '0;
      line_cnt <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
      ready_q  <= 1'b0;
      wceb_q   <= 1'b1;
      waddr_q  <= '0;
      di_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q    <= bus.LOAD_LEN;
            line_cnt <= '0;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            if (bus.LOAD_LEN == 14'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= COLLECT;
              ready_q <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 2'd1;
            case (beat_cnt)
              2'd0: line_buf[31:0]  <= bus.HOST_DATA;
              2'd1: line_buf[63:32] <= bus.HOST_DATA;
              2'd2: line_buf[95:64] <= bus.HOST_DATA;
              default: begin
                // Fourth beat goes straight into the write register, so the
                // line is presented on DI during the single WRITE cycle.
                state   <= WRITE;
                ready_q <= 1'b0;
                wceb_q  <= 1'b0;
                waddr_q <= line_cnt;
                di_q    <= {bus.HOST_DATA, line_buf};
              end
            endcase
          end
        end

        WRITE: begin
          wceb_q <= 1'b1;
          if (line_cnt == len_q - 14'd1) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            line_cnt <= line_cnt + 14'd1;
            state    <= COLLECT;
            ready_q  <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL)         checksum_q <= '0;
    else if (start_ok) checksum_q <= '0;
    else if (beat_ok)  checksum_q <= checksum_q ^ bus.HOST_DATA;
  end

  assign bus.CHECKSUM = checksum_q;
`else
  assign bus.CHECKSUM = 32'd0;
`endif

  assign bus.HOST_READY = ready_q;
  assign bus.WCEBI      = wceb_q;
  assign bus.WADDRI     = waddr_q;
  assign bus.DI         = di_q;
  assign bus.PURGE      = busy_q;
  assign bus.LOAD_BUSY  = busy_q;
  assign bus.LOAD_DONE  = done_q;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RSTL, input, 1, the reset: asynchronous, active-low.
REQ-003 SHALL have port LOAD_START, input, 1, a one-cycle load request, sampled only in IDLE.
REQ-004 SHALL have port LOAD_LEN, input, 14, the number of 128-bit instruction lines to load, sampled together with LOAD_START.
REQ-005 SHALL have port HOST_VALID, input, 1, meaning HOST_DATA is valid.
REQ-006 SHALL have port HOST_DATA, input, 32, a microcode word beat.
REQ-007 SHALL have port HOST_READY, output, 1, meaning the loader accepts a beat this cycle.
REQ-008 SHALL have port WADDRI, output, 14, the instruction SRAM write address.
REQ-009 SHALL have port WCEBI, output, 1, the instruction SRAM write strobe, active-low.
REQ-010 SHALL have port DI, output, 128, the instruction SRAM write data.
REQ-011 SHALL have port PURGE, output, 1, which holds the sequencer in purge while a load is in progress.
REQ-012 SHALL have port LOAD_BUSY, output, 1, meaning the FSM is not in IDLE.
REQ-013 SHALL have port LOAD_DONE, output, 1, a one-cycle pulse at completion.
REQ-014 SHALL have port CHECKSUM, output, 32, the XOR of all accepted beats in the current or last load.

Function
REQ-015 SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-016 SHALL, in IDLE with LOAD_START=1, latch LOAD_LEN, clear the line counter, beat counter and checksum, and go to COLLECT next cycle; if LOAD_LEN=0 it SHALL go directly to DONE with no SRAM writes.
REQ-017 SHALL ignore LOAD_START outside IDLE.
REQ-018 SHALL drive HOST_READY=1 only in COLLECT; a beat is accepted when HOST_VALID&HOST_READY.
REQ-019 SHALL pack accepted beats little-endian: beat 0 -> DI[31:0], beat 1 -> [63:32], beat 2 -> [95:64], beat 3 -> [127:96]; a 2-bit beat counter wraps 3->0.
REQ-020 SHALL move from COLLECT to WRITE on the cycle after the 4th beat is accepted, with HOST_READY=0 during WRITE.
REQ-021 SHALL, in WRITE, hold WCEBI=0 for exactly one cycle, with WADDRI equal to the line counter and DI equal to the assembled line.
REQ-022 SHALL, after WRITE, go to DONE if line counter = latched LEN-1, else increment the line counter and return to COLLECT.
REQ-023 SHALL hold the line counter within 14 bits with no wrap; lines are written to addresses 0..LEN-1, and LEN=16383 writes up to address 16382.
REQ-024 SHALL, in DONE, hold LOAD_DONE=1 for one cycle, then return to IDLE.
REQ-025 SHALL drive PURGE=LOAD_BUSY=1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-026 SHALL, outside WRITE, hold WCEBI=1 and keep WADDRI/DI at their last values.
REQ-027 SHALL, on HOST_VALID low in COLLECT, wait indefinitely with no timeout.

Reset
REQ-028 SHALL, on RSTL low (at any time, including mid-load), immediately go to IDLE with HOST_READY=0, WCEBI=1, WADDRI=0, DI=0, PURGE=0, LOAD_BUSY=0, LOAD_DONE=0, CHECKSUM=0, and all counters 0.
REQ-029 SHALL NOT complete a partially collected line after reset, and no SRAM write SHALL follow reset.

Configuration
REQ-030 SHALL, with INST_LOADER_CHECKSUM_EN defined, XOR each accepted beat into a 32-bit checksum register that is cleared on an accepted LOAD_START and held after DONE.
REQ-031 SHALL, with INST_LOADER_CHECKSUM_EN undefined, tie CHECKSUM to 0 and implement no checksum register; all other behaviour is identical.

Verification
REQ-032 SHALL cover: LOAD_START, LEN=1; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one WCEBI=0 cycle, WADDRI=0, DI=0x44444444_33333333_22222222_11111111, LOAD_DONE one cycle later, CHECKSUM=0x44444444 (macro on).
REQ-033 SHALL cover: LEN=3 with HOST_VALID toggling every other cycle -> writes at WADDRI 0, 1, 2 in order; PURGE high from the cycle after LOAD_START through DONE.
REQ-034 SHALL cover: LEN=0 -> no WCEBI pulse, HOST_READY never high, LOAD_DONE asserted the cycle after LOAD_START.
REQ-035 SHALL cover: RSTL pulsed low after 2 beats of line 1 in a LEN=2 load -> all outputs at reset values, no further write; a new LEN=1 load then writes address 0 correctly.
REQ-036 SHALL cover: LOAD_START reasserted during COLLECT with LEN=5 -> ignored; the original LEN=2 load completes with exactly 2 writes.
